// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - decode-stage register file with writeback receiver and hazard scoreboard
// Optional feature macro: RF_WB_BYPASS_EN (same-cycle writeback-to-read bypass and early wakeup).
module decode_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [ADDR_W-1:0]        rs1_addr,
  input  logic [ADDR_W-1:0]        rs2_addr,
  output logic [DATA_W-1:0]        rs1_data,
  output logic [DATA_W-1:0]        rs2_data,
  input  logic                     issue_valid,
  input  logic                     issue_we,
  input  logic [ADDR_W-1:0]        issue_rd,
  output logic                     stall,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [PEND_W-1:0] pend [NUM_REGS];

  logic                wb_hit;
  logic                issue_hit;
  logic                rs1_not_ready;
  logic                rs2_not_ready;
  logic                rd_full;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  assign wb_hit = wb_we && (wb_addr != '0);

  // Register array; r0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = regs[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_data = regs[rs2_addr];
    end
`ifdef RF_WB_BYPASS_EN
    if (wb_hit && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
    end
    if (wb_hit && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
    end
`endif
  end

  // A source is ready when nothing is in flight to it, or (with bypass) when the
  // last in-flight write is retiring in this very cycle.
  always_comb begin
    rs1_not_ready = (rs1_addr != '0) && (pend[rs1_addr] != '0);
    rs2_not_ready = (rs2_addr != '0) && (pend[rs2_addr] != '0);
`ifdef RF_WB_BYPASS_EN
    if (wb_hit && (wb_addr == rs1_addr) && (pend[rs1_addr] == PEND_ONE)) begin
      rs1_not_ready = 1'b0;
    end
    if (wb_hit && (wb_addr == rs2_addr) && (pend[rs2_addr] == PEND_ONE)) begin
      rs2_not_ready = 1'b0;
    end
`endif
  end

  // The full check deliberately ignores a same-cycle retire to keep the path short.
  assign rd_full   = issue_we && (issue_rd != '0) && (pend[issue_rd] == PEND_MAX);
  assign stall     = issue_valid && (rs1_not_ready || rs2_not_ready || rd_full);
  assign issue_hit = issue_valid && !stall && issue_we && (issue_rd != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_hit) begin
      inc_vec[issue_rd] = 1'b1;
    end
    if (wb_hit) begin
      dec_vec[wb_addr] = 1'b1;
    end
  end

  // Pending-write counters; a retire against an empty counter holds it at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          pend[i] <= pend[i] + PEND_ONE;
        end else if (!inc_vec[i] && dec_vec[i] && (pend[i] != '0)) begin
          pend[i] <= pend[i] - PEND_ONE;
        end
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_vec[i] = (pend[i] != '0);
    end
  end

endmodule

// File: tb/tb_decode_regfile.sv
// tb/tb_decode_regfile.sv - directed and randomized checks of decode_regfile against a reference model
module tb_decode_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;
  localparam int PMAX   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wb_we = 1'b0;
  logic [ADDR_W-1:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic [ADDR_W-1:0] rs1_addr = '0;
  logic [ADDR_W-1:0] rs2_addr = '0;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              issue_valid = 1'b0;
  logic              issue_we = 1'b0;
  logic [ADDR_W-1:0] issue_rd = '0;
  logic              stall;
  logic [NREGS-1:0]  busy_vec;

  int n_checks = 0;
  int n_fail = 0;

  int          mpend [NREGS];
  logic [31:0] mreg  [NREGS];

  decode_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PEND_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic bit m_not_ready(input int a);
    if (a == 0 || mpend[a] == 0) return 1'b0;
`ifdef RF_WB_BYPASS_EN
    if (mpend[a] == 1 && wb_we && int'(wb_addr) == a) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    if (!issue_valid) return 1'b0;
    return m_not_ready(int'(rs1_addr)) || m_not_ready(int'(rs2_addr)) ||
           (issue_we && issue_rd != 0 && mpend[issue_rd] == PMAX);
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return 32'h0;
`ifdef RF_WB_BYPASS_EN
    if (wb_we && int'(wb_addr) == a) return wb_data;
`endif
    return mreg[a];
  endfunction

  function automatic logic [NREGS-1:0] m_busy();
    logic [NREGS-1:0] v;
    v = '0;
    for (int i = 1; i < NREGS; i++) v[i] = (mpend[i] != 0);
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) begin
      mpend[i] = 0;
      mreg[i]  = 32'h0;
    end
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0;
  endtask

  // Advance one clock edge, folding the current inputs into the model.
  task automatic tick();
    bit st;
    st = m_stall();
    @(posedge clk);
    if (issue_valid && !st && issue_we && issue_rd != 0) mpend[issue_rd]++;
    if (wb_we && wb_addr != 0) begin
      if (mpend[wb_addr] > 0) mpend[wb_addr]--;
      mreg[wb_addr] = wb_data;
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rs1_addr = 5'd1; rs2_addr = 5'd31; issue_valid = 1'b0;
    #1;
    n_checks++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs1 got %h want 0", rs1_data); end
    n_checks++; if (rs2_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs2 got %h want 0", rs2_data); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_checks++; if (busy_vec !== '0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy_vec); end
    tick();
  endtask

  task automatic test_write_read();
    idle();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    idle(); rs1_addr = 5'd5;
    #1;
    n_checks++; if (rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_r5 got %h want deadbeef", rs1_data); end
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    tick();
    idle(); rs2_addr = 5'd0;
    #1;
    n_checks++; if (rs2_data !== 32'h0) begin n_fail++; $display("FAIL write_r0 got %h want 0", rs2_data); end
    wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'hA5A5_0F0F; rs1_addr = 5'd6;
    #1;
`ifdef RF_WB_BYPASS_EN
    n_checks++; if (rs1_data !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL bypass_r6 got %h want a5a50f0f", rs1_data); end
`else
    n_checks++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL nobypass_r6 got %h want 0", rs1_data); end
`endif
    tick();
    idle();
  endtask

  task automatic test_raw();
    do_reset();
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd3;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_issue_rd3 stall got %b want 0", stall); end
    tick();
    idle(); issue_valid = 1'b1; rs1_addr = 5'd3;
    #1;
    n_checks++; if (busy_vec[3] !== 1'b1) begin n_fail++; $display("FAIL raw_busy3 got %b want 1", busy_vec[3]); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_dep_stall got %b want 1", stall); end
    tick();
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    #1;
`ifdef RF_WB_BYPASS_EN
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_retire_stall got %b want 0", stall); end
    n_checks++; if (rs1_data !== 32'h55) begin n_fail++; $display("FAIL raw_retire_data got %h want 55", rs1_data); end
`else
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_retire_stall got %b want 1", stall); end
    n_checks++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL raw_retire_data got %h want 0", rs1_data); end
`endif
    tick();
    wb_we = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_next_stall got %b want 0", stall); end
    n_checks++; if (rs1_data !== 32'h55) begin n_fail++; $display("FAIL raw_next_data got %h want 55", rs1_data); end
    tick();
    idle();
  endtask

  task automatic test_waw();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd7;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_issue%0d stall got %b want 0", k, stall); end
      tick();
    end
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_full stall got %b want 1", stall); end
    tick();
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h7777;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_full_retire stall got %b want 1", stall); end
    tick();
    wb_we = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_retry stall got %b want 0", stall); end
    tick();
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_refull stall got %b want 1", stall); end
    n_checks++; if (busy_vec[7] !== 1'b1) begin n_fail++; $display("FAIL waw_busy7 got %b want 1", busy_vec[7]); end
    idle();
    tick();
  endtask

  task automatic test_inc_dec();
    do_reset();
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd9;
    tick();
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL incdec_stall got %b want 0", stall); end
    tick();
    idle();
    #1;
    n_checks++; if (busy_vec[9] !== 1'b1) begin n_fail++; $display("FAIL incdec_busy9 got %b want 1", busy_vec[9]); end
    wb_we = 1'b1; wb_addr = 5'd9;
    tick();
    idle();
    #1;
    n_checks++; if (busy_vec[9] !== 1'b0) begin n_fail++; $display("FAIL incdec_drain9 got %b want 0", busy_vec[9]); end
  endtask

  task automatic test_random();
    logic [NREGS-1:0] eb;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_we    = 1'($urandom_range(0, 1));
      issue_rd    = ADDR_W'($urandom_range(0, 7));
      rs1_addr    = ADDR_W'($urandom_range(0, 7));
      rs2_addr    = ADDR_W'($urandom_range(0, 7));
      wb_we       = ($urandom_range(0, 2) == 0);
      wb_addr     = ADDR_W'($urandom_range(0, 7));
      wb_data     = $urandom;
      #1;
      eb = m_busy();
      n_checks++; if (rs1_data !== m_read(int'(rs1_addr))) begin n_fail++; $display("FAIL rand_rs1 c=%0d got %h want %h", c, rs1_data, m_read(int'(rs1_addr))); end
      n_checks++; if (rs2_data !== m_read(int'(rs2_addr))) begin n_fail++; $display("FAIL rand_rs2 c=%0d got %h want %h", c, rs2_data, m_read(int'(rs2_addr))); end
      n_checks++; if (stall !== m_stall()) begin n_fail++; $display("FAIL rand_stall c=%0d got %b want %b", c, stall, m_stall()); end
      n_checks++; if (busy_vec !== eb) begin n_fail++; $display("FAIL rand_busy c=%0d got %h want %h", c, busy_vec, eb); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h77;
    tick();
    idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd4;
    tick();
    tick();
    idle(); rs1_addr = 5'd4;
    #1;
    n_checks++; if (busy_vec[4] !== 1'b1 || rs1_data !== 32'h77) begin n_fail++; $display("FAIL mid_setup busy4=%b r4=%h want 1 77", busy_vec[4], rs1_data); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy_vec !== '0) begin n_fail++; $display("FAIL mid_reset_busy got %h want 0", busy_vec); end
    n_checks++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_r4 got %h want 0", rs1_data); end
    clear_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL mid_after_r4 got %h want 0", rs1_data); end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_write_read();
    test_raw();
    test_waw();
    test_inc_dec();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_regfile.md
Name: decode_regfile

Overview:
- Register-file write receiver and hazard scoreboard in the DECODE stage.
- Accepts the writeback bus from WRITEBACK (data plus write-enable) and commits it to a 32-entry register file.
- Serves two combinational read ports to DECODE.
- Tracks in-flight writes per register and raises a stall to DECODE when a source operand is not yet available.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W
PEND_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2**PEND_W - 1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
wb_we  input  1  writeback write-enable (is_reg_write from WRITEBACK)
wb_addr  input  ADDR_W  writeback destination register
wb_data  input  DATA_W  writeback value (WRITEBACK_DATA)
rs1_addr  input  ADDR_W  read port 1 index
rs2_addr  input  ADDR_W  read port 2 index
rs1_data  output  DATA_W  read port 1 value
rs2_data  output  DATA_W  read port 2 value
issue_valid  input  1  DECODE presents an instruction for issue this cycle
issue_we  input  1  the presented instruction writes a register
issue_rd  input  ADDR_W  destination of the presented instruction
stall  output  1  instruction must be held in DECODE; no issue this cycle
busy_vec  output  NUM_REGS  bit i = 1 when pending counter i is non-zero

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. Assertion clears all registers and all pending counters to 0 immediately. Outputs go to 0: rs1_data, rs2_data, stall, busy_vec. Reset mid-operation discards all in-flight scoreboard state; WRITEBACK must also be flushed by the same reset.
- Register 0:
  - Reads always return 0.
  - Writes with wb_addr = 0 are ignored.
  - Issue with issue_rd = 0 never increments a counter.
  - Register 0 never stalls.
- Write:
  - On rising clk with wb_we = 1 and wb_addr != 0: reg[wb_addr] <= wb_data.
  - Data is visible through the array from the next cycle; see bypass for same-cycle visibility.
- Read:
  - Combinational: rsN_data = reg[rsN_addr], zero-latency.
  - Same-cycle bypass (with RF_WB_BYPASS_EN): if wb_we = 1, wb_addr = rsN_addr and wb_addr != 0, then rsN_data = wb_data.
- Issue accept:
  - issue = issue_valid && !stall.
  - On an accepted issue with issue_we = 1 and issue_rd != 0, pend[issue_rd] increments at the clock edge.
- Retire: wb_we = 1 with wb_addr != 0 decrements pend[wb_addr] at the clock edge.
- Simultaneous events:
  - Increment and decrement on the same register in the same cycle leave the counter unchanged.
  - Events on different registers update independently.
- Counter bounds:
  - Decrement of a zero counter is a protocol error; the counter holds at 0. It is an assertion target for verification.
  - Increment never exceeds the maximum because of the stall rule below.
- Source-not-ready for operand N:
  - Condition: rsN_addr != 0 and pend[rsN_addr] != 0.
  - Exception: with bypass enabled, the operand is ready when pend[rsN_addr] = 1 and a retire to rsN_addr occurs this cycle.
  - Both rs ports are always treated as used; DECODE drives 0 for unused sources.
- Stall condition: stall = issue_valid && (rs1 not ready || rs2 not ready || (issue_we && issue_rd != 0 && pend[issue_rd] == max)).
  - The max check uses the counter value before this cycle's retire.
  - stall = 0 whenever issue_valid = 0.
- Counter wrap-around is impossible by construction; no silent wrap is permitted.
- busy_vec is registered state, decoded directly from the counters; bit 0 is always 0.

Optional Feature:
RF_WB_BYPASS_EN
- Defined: same-cycle write-to-read bypass as described above. The stall exception for pend = 1 with a matching retire applies, so a dependent instruction issues in the writeback cycle.
- Undefined: reads return only the stored array value. Any non-zero pending count on a source stalls, including during the retiring cycle. The dependent instruction issues one cycle later.
- Port list is identical in both builds.

Test Plan:
- Reset then read: rst_n low, then high; read r1, r31 -> rs1_data = rs2_data = 0, stall = 0, busy_vec = 0.
- Basic write/read: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF for one edge; then rs1_addr=5 -> rs1_data = 0xDEADBEEF. Write to r0 with 0x1234 -> rs2_addr=0 reads 0.
- RAW stall:
  - Setup: issue rd=3 with issue_we=1, then issue rs1=3; expect busy_vec[3]=1 and stall=1.
  - Retire wb_addr=3, wb_data=0x55 with bypass: same cycle stall=0, rs1_data=0x55.
  - Without bypass: stall=1 that cycle, 0 next cycle.
- WAW counting:
  - Setup: issue rd=7 three times (PEND_W=2) -> pend=3. Fourth issue rd=7 -> stall=1.
  - One retire to r7 plus a simultaneous rd=7 issue: the fourth issue still stalls (max check uses pre-retire value); pend becomes 2. The retry next cycle issues and pend stays at 3.
- Simultaneous inc/dec: pend[9]=1; same cycle issue rd=9 and retire r9 -> pend[9] stays 1, busy_vec[9]=1.
- Reset mid-flight: pend[4]=2, reg[4]=0x77; assert rst_n asynchronously between edges -> busy_vec=0 and reg[4] reads 0 immediately, before the next clk edge.
